// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// =============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Round-robin, burst-limited arbiter sharing one UART transmitter.
//            Define UART_TX_ARB_STATS_EN to build the STAT_WORDS counter.
// Revision : 1.0 - initial release
// =============================================================================
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int MAX_BURST    = 4,
    parameter int GUARD_CYCLES = 2
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [NUM_REQ-1:0]     REQ_VAL,
    input  logic [16*NUM_REQ-1:0]  REQ_DATA,
    input  logic [NUM_REQ-1:0]     REQ_LAST,
    output logic [NUM_REQ-1:0]     REQ_ACK,
    output logic [NUM_REQ-1:0]     GRANT,
    output logic [15:0]            TX_DATA,
    output logic                   TX_DATA_VAL,
    input  logic                   TX_BUSY,
    output logic [31:0]            STAT_WORDS
);

    localparam int         c_IDX_W      = $clog2(NUM_REQ);
    localparam logic [2:0] c_S_IDLE     = 3'd0;
    localparam logic [2:0] c_S_ARB      = 3'd1;
    localparam logic [2:0] c_S_SEND     = 3'd2;
    localparam logic [2:0] c_S_GUARD    = 3'd3;
    localparam logic [2:0] c_S_DRAIN    = 3'd4;
    localparam logic [7:0] c_MAX_BURST  = 8'(MAX_BURST);
    localparam logic [3:0] c_GUARD_LAST = 4'(GUARD_CYCLES - 1);

    logic [2:0]         r_state, w_state_nxt;
    logic [c_IDX_W-1:0] r_owner, w_owner_nxt;
    logic [c_IDX_W-1:0] r_last_owner, w_last_owner_nxt;
    logic [c_IDX_W-1:0] w_arb_idx;
    logic               w_arb_found;
    logic [7:0]         r_burst, w_burst_nxt;
    logic [3:0]         r_guard, w_guard_nxt;
    logic               r_last_flag, w_last_flag_nxt;
    logic [NUM_REQ-1:0] r_grant, w_grant_nxt;
    logic [NUM_REQ-1:0] r_ack, w_ack_nxt;
    logic [15:0]        r_tx_data, w_tx_data_nxt;
    logic               r_tx_val, w_tx_val_nxt;
    logic [15:0]        w_words [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_words[g] = REQ_DATA[16*g +: 16];
    end

    // Rotating search that starts just after the previous owner.
    always_comb begin
        int j;
        j           = 0;
        w_arb_found = 1'b0;
        w_arb_idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            j = (int'(r_last_owner) + k) % NUM_REQ;
            if (!w_arb_found && REQ_VAL[j[c_IDX_W-1:0]]) begin
                w_arb_found = 1'b1;
                w_arb_idx   = j[c_IDX_W-1:0];
            end
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_owner_nxt      = r_owner;
        w_last_owner_nxt = r_last_owner;
        w_burst_nxt      = r_burst;
        w_guard_nxt      = r_guard;
        w_last_flag_nxt  = r_last_flag;
        w_grant_nxt      = r_grant;
        w_ack_nxt        = '0;
        w_tx_data_nxt    = r_tx_data;
        w_tx_val_nxt     = 1'b0;
        case (r_state)
            c_S_IDLE: begin
                if (|REQ_VAL) w_state_nxt = c_S_ARB;
            end
            c_S_ARB: begin
                w_grant_nxt = '0;
                if (w_arb_found) begin
                    w_owner_nxt            = w_arb_idx;
                    w_grant_nxt[w_arb_idx] = 1'b1;
                    w_burst_nxt            = '0;
                    w_state_nxt            = c_S_SEND;
                end else begin
                    w_state_nxt = c_S_IDLE;
                end
            end
            c_S_SEND: begin
                // A vanished owner request releases the grant even while busy.
                if (!REQ_VAL[r_owner]) begin
                    w_last_owner_nxt = r_owner;
                    w_state_nxt      = c_S_ARB;
                end else if (!TX_BUSY) begin
                    w_tx_data_nxt   = w_words[r_owner];
                    w_tx_val_nxt    = 1'b1;
                    w_ack_nxt       = r_grant;
                    w_last_flag_nxt = REQ_LAST[r_owner];
                    if (r_burst < c_MAX_BURST) w_burst_nxt = r_burst + 8'd1;
                    w_guard_nxt     = '0;
                    w_state_nxt     = c_S_GUARD;
                end
            end
            c_S_GUARD: begin
                if (r_guard == c_GUARD_LAST) w_state_nxt = c_S_DRAIN;
                else                         w_guard_nxt = r_guard + 4'd1;
            end
            c_S_DRAIN: begin
                if (!TX_BUSY) begin
                    if (r_last_flag || (r_burst == c_MAX_BURST)) begin
                        w_last_owner_nxt = r_owner;
                        w_state_nxt      = c_S_ARB;
                    end else begin
                        w_state_nxt = c_S_SEND;
                    end
                end
            end
            default: w_state_nxt = c_S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= c_S_IDLE;
            r_owner      <= '0;
            r_last_owner <= c_IDX_W'(NUM_REQ - 1);
            r_burst      <= '0;
            r_guard      <= '0;
            r_last_flag  <= 1'b0;
            r_grant      <= '0;
            r_ack        <= '0;
            r_tx_data    <= '0;
            r_tx_val     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_owner      <= w_owner_nxt;
            r_last_owner <= w_last_owner_nxt;
            r_burst      <= w_burst_nxt;
            r_guard      <= w_guard_nxt;
            r_last_flag  <= w_last_flag_nxt;
            r_grant      <= w_grant_nxt;
            r_ack        <= w_ack_nxt;
            r_tx_data    <= w_tx_data_nxt;
            r_tx_val     <= w_tx_val_nxt;
        end
    end

    assign REQ_ACK     = r_ack;
    assign GRANT       = r_grant;
    assign TX_DATA     = r_tx_data;
    assign TX_DATA_VAL = r_tx_val;

`ifdef UART_TX_ARB_STATS_EN
    logic [31:0] r_stat_words;
    always_ff @(posedge CLK) begin
        if (RST)           r_stat_words <= '0;
        else if (r_tx_val) r_stat_words <= r_stat_words + 32'd1;
    end
    assign STAT_WORDS = r_stat_words;
`else
    assign STAT_WORDS = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// =============================================================================
// Module   : tb_uart_tx_arbiter
// Purpose  : Self-checking bench for uart_tx_arbiter with a queue-level model.
// Revision : 1.0 - initial release
// =============================================================================
module tb_uart_tx_arbiter;

    localparam int c_NR    = 4;
    localparam int c_MB    = 4;
    localparam int c_GC    = 2;
    localparam int c_DEPTH = 16;

    logic        CLK = 1'b0;
    logic        RST;
    logic [3:0]  REQ_VAL;
    logic [63:0] REQ_DATA;
    logic [3:0]  REQ_LAST;
    logic [3:0]  REQ_ACK;
    logic [3:0]  GRANT;
    logic [15:0] TX_DATA;
    logic        TX_DATA_VAL;
    logic        TX_BUSY;
    logic [31:0] STAT_WORDS;

    uart_tx_arbiter #(.NUM_REQ(c_NR), .MAX_BURST(c_MB), .GUARD_CYCLES(c_GC)) u_dut (
        .CLK(CLK), .RST(RST), .REQ_VAL(REQ_VAL), .REQ_DATA(REQ_DATA),
        .REQ_LAST(REQ_LAST), .REQ_ACK(REQ_ACK), .GRANT(GRANT), .TX_DATA(TX_DATA),
        .TX_DATA_VAL(TX_DATA_VAL), .TX_BUSY(TX_BUSY), .STAT_WORDS(STAT_WORDS)
    );

    always #5 CLK = ~CLK;

    // Per-requester word queues and observed/expected transmit streams.
    logic [15:0] mem_data [c_NR][c_DEPTH];
    logic        mem_last [c_NR][c_DEPTH];
    int          q_cnt    [c_NR];
    int          q_head   [c_NR];
    int          obs_req[$];
    logic [15:0] obs_data[$];
    int          exp_req[$];
    logic [15:0] exp_data[$];
    int          viol_busy, viol_ack, viol_gap;
    bit          timed_out;
    int          checks = 0;
    int          errors = 0;

    task automatic do_reset();
        RST = 1'b1; REQ_VAL = '0; REQ_DATA = '0; REQ_LAST = '0; TX_BUSY = 1'b0;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
    endtask

    task automatic clear_queues();
        for (int i = 0; i < c_NR; i++) begin q_cnt[i] = 0; q_head[i] = 0; end
    endtask

    task automatic push_word(input int r, input logic [15:0] d, input logic l);
        mem_data[r][q_cnt[r]] = d;
        mem_last[r][q_cnt[r]] = l;
        q_cnt[r]++;
    endtask

    task automatic apply_inputs();
        for (int i = 0; i < c_NR; i++) begin
            if (q_head[i] < q_cnt[i]) begin
                REQ_VAL[i] = 1'b1;
                REQ_DATA[16*i +: 16] = mem_data[i][q_head[i]];
                REQ_LAST[i] = mem_last[i][q_head[i]];
            end else begin
                REQ_VAL[i] = 1'b0;
                REQ_DATA[16*i +: 16] = 16'($urandom);
                REQ_LAST[i] = 1'($urandom);
            end
        end
    endtask

    // Transaction-level model: rotate from last owner, serve up to MAX_BURST words
    // or until the packet ends or the requester runs dry.
    task automatic build_expected();
        int h[c_NR];
        int ptr, owner, n, j;
        bit found, lastf;
        exp_req.delete(); exp_data.delete();
        for (int i = 0; i < c_NR; i++) h[i] = 0;
        ptr = c_NR - 1;
        forever begin
            found = 1'b0; owner = 0;
            for (int k = 1; k <= c_NR; k++) begin
                j = (ptr + k) % c_NR;
                if (!found && h[j] < q_cnt[j]) begin found = 1'b1; owner = j; end
            end
            if (!found) break;
            n = 0;
            do begin
                exp_req.push_back(owner);
                exp_data.push_back(mem_data[owner][h[owner]]);
                lastf = mem_last[owner][h[owner]];
                h[owner]++; n++;
            end while (!lastf && n < c_MB && h[owner] < q_cnt[owner]);
            ptr = owner;
        end
    endtask

    // Drives the queued traffic and a simple UART busy model; records what was sent.
    task automatic run_traffic(input int budget, input bit rand_busy);
        int cyc, busy_left, last_strobe, done, idx, nbits;
        bit prev_busy, all_empty;
        obs_req.delete(); obs_data.delete();
        viol_busy = 0; viol_ack = 0; viol_gap = 0; timed_out = 1'b0;
        busy_left = 0; last_strobe = -1000; done = 0; cyc = 0;
        TX_BUSY = 1'b0; prev_busy = 1'b0;
        apply_inputs();
        forever begin
            @(posedge CLK); #1; cyc++;
            if (TX_DATA_VAL === 1'b1) begin
                if (prev_busy) viol_busy++;
                if (cyc - last_strobe < c_GC + 2) viol_gap++;
                last_strobe = cyc;
                idx = -1; nbits = 0;
                for (int i = 0; i < c_NR; i++) if (REQ_ACK[i]) begin idx = i; nbits++; end
                if (nbits != 1) viol_ack++;
                obs_req.push_back(idx);
                obs_data.push_back(TX_DATA);
                if (idx >= 0 && q_head[idx] < q_cnt[idx]) q_head[idx]++;
                if (rand_busy) busy_left = $urandom_range(0, 6);
            end
            if (REQ_ACK !== (GRANT & {c_NR{TX_DATA_VAL}})) viol_ack++;
            if ($countones(GRANT) > 1) viol_ack++;
            if (rand_busy) begin
                TX_BUSY = (busy_left > 0) || ($urandom_range(0, 7) == 0);
                if (busy_left > 0) busy_left--;
            end else begin
                TX_BUSY = 1'b0;
            end
            prev_busy = TX_BUSY;
            apply_inputs();
            all_empty = 1'b1;
            for (int i = 0; i < c_NR; i++) if (q_head[i] < q_cnt[i]) all_empty = 1'b0;
            if (all_empty && GRANT === '0) done++; else done = 0;
            if (done >= 4) break;
            if (cyc >= budget) begin timed_out = 1'b1; break; end
        end
        TX_BUSY = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (GRANT !== 4'h0) begin errors++; $display("FAIL reset_grant: got %h expected 0", GRANT); end
        checks++; if (REQ_ACK !== 4'h0) begin errors++; $display("FAIL reset_ack: got %h expected 0", REQ_ACK); end
        checks++; if (TX_DATA !== 16'h0) begin errors++; $display("FAIL reset_txdata: got %h expected 0", TX_DATA); end
        checks++; if (TX_DATA_VAL !== 1'b0) begin errors++; $display("FAIL reset_txval: got %b expected 0", TX_DATA_VAL); end
        checks++; if (STAT_WORDS !== 32'h0) begin errors++; $display("FAIL reset_stat: got %0d expected 0", STAT_WORDS); end
    endtask

    task automatic test_single();
        do_reset();
        REQ_VAL = 4'b0001; REQ_DATA[15:0] = 16'hA55A; REQ_LAST = 4'b0001;
        @(posedge CLK); #1;
        checks++; if (GRANT !== 4'h0) begin errors++; $display("FAIL single_grant_early: got %h expected 0", GRANT); end
        @(posedge CLK); #1;
        checks++; if (GRANT !== 4'b0001) begin errors++; $display("FAIL single_grant: got %b expected 0001", GRANT); end
        checks++; if (TX_DATA_VAL !== 1'b0) begin errors++; $display("FAIL single_val_early: got %b expected 0", TX_DATA_VAL); end
        @(posedge CLK); #1;
        checks++; if (TX_DATA_VAL !== 1'b1) begin errors++; $display("FAIL single_val: got %b expected 1", TX_DATA_VAL); end
        checks++; if (TX_DATA !== 16'hA55A) begin errors++; $display("FAIL single_data: got %h expected a55a", TX_DATA); end
        checks++; if (REQ_ACK !== 4'b0001) begin errors++; $display("FAIL single_ack: got %b expected 0001", REQ_ACK); end
        REQ_VAL = 4'b0000;
        @(posedge CLK); #1;
        checks++; if (TX_DATA_VAL !== 1'b0 || REQ_ACK !== 4'h0) begin errors++; $display("FAIL single_pulse: got val %b ack %b expected 0 0", TX_DATA_VAL, REQ_ACK); end
        repeat (6) @(posedge CLK); #1;
        checks++; if (GRANT !== 4'h0) begin errors++; $display("FAIL single_release: got %b expected 0000", GRANT); end
    endtask

    task automatic test_round_robin();
        int order[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        logic [15:0] d;
        do_reset(); clear_queues();
        for (int w = 0; w < 2; w++)
            for (int i = 0; i < c_NR; i++) push_word(i, 16'hC000 + 16'(i * 16 + w), 1'b1);
        run_traffic(1000, 1'b0);
        checks++; if (timed_out || obs_req.size() != 8) begin errors++; $display("FAIL rr_count: got %0d words expected 8", obs_req.size()); end
        for (int k = 0; k < 8 && k < obs_req.size(); k++) begin
            d = 16'hC000 + 16'(order[k] * 16 + k / 4);
            checks++; if (obs_req[k] != order[k] || obs_data[k] !== d) begin
                errors++; $display("FAIL rr_word%0d: got req %0d data %h expected req %0d data %h", k, obs_req[k], obs_data[k], order[k], d);
            end
        end
    endtask

    task automatic test_burst();
        int          order[7] = '{2, 2, 2, 2, 3, 2, 2};
        logic [15:0] data[7]  = '{16'h2200, 16'h2201, 16'h2202, 16'h2203, 16'h3300, 16'h2204, 16'h2205};
        do_reset(); clear_queues();
        for (int w = 0; w < 6; w++) push_word(2, 16'h2200 + 16'(w), 1'b0);
        push_word(3, 16'h3300, 1'b1);
        run_traffic(1000, 1'b0);
        checks++; if (timed_out || obs_req.size() != 7) begin errors++; $display("FAIL burst_count: got %0d words expected 7", obs_req.size()); end
        for (int k = 0; k < 7 && k < obs_req.size(); k++) begin
            checks++; if (obs_req[k] != order[k] || obs_data[k] !== data[k]) begin
                errors++; $display("FAIL burst_word%0d: got req %0d data %h expected req %0d data %h", k, obs_req[k], obs_data[k], order[k], data[k]);
            end
        end
    endtask

    task automatic test_busy_gating();
        int n, strobes;
        do_reset();
        TX_BUSY = 1'b1; REQ_VAL = 4'b0001; REQ_DATA[15:0] = 16'h1111; REQ_LAST = 4'b0001;
        n = 0;
        while (GRANT !== 4'b0001 && n < 10) begin @(posedge CLK); #1; n++; end
        checks++; if (GRANT !== 4'b0001) begin errors++; $display("FAIL busy_grant: got %b expected 0001", GRANT); end
        strobes = 0;
        repeat (50) begin
            @(posedge CLK); #1;
            if (TX_DATA_VAL !== 1'b0) strobes++;
            REQ_DATA[15:0] = 16'($urandom);
        end
        checks++; if (strobes != 0) begin errors++; $display("FAIL busy_hold: got %0d strobes expected 0", strobes); end
        REQ_DATA[15:0] = 16'h5A5A; TX_BUSY = 1'b0;
        @(posedge CLK); #1;
        checks++; if (TX_DATA_VAL !== 1'b1) begin errors++; $display("FAIL busy_release_val: got %b expected 1", TX_DATA_VAL); end
        checks++; if (TX_DATA !== 16'h5A5A) begin errors++; $display("FAIL busy_release_data: got %h expected 5a5a", TX_DATA); end
        REQ_VAL = 4'b0000;
        repeat (8) @(posedge CLK); #1;
    endtask

    task automatic test_reset_mid();
        int n;
        do_reset();
        REQ_VAL = 4'b0100; REQ_DATA[47:32] = 16'h1234; REQ_LAST = 4'b0000;
        n = 0;
        while (TX_DATA_VAL !== 1'b1 && n < 20) begin @(posedge CLK); #1; n++; end
        checks++; if (TX_DATA_VAL !== 1'b1) begin errors++; $display("FAIL rstmid_first: got %b expected 1", TX_DATA_VAL); end
        RST = 1'b1; REQ_VAL = 4'b0101; REQ_DATA[15:0] = 16'h0F0F; REQ_LAST = 4'b0101;
        @(posedge CLK); #1;
        checks++; if (GRANT !== 4'h0 || REQ_ACK !== 4'h0) begin errors++; $display("FAIL rstmid_grant_ack: got %b %b expected 0000 0000", GRANT, REQ_ACK); end
        checks++; if (TX_DATA_VAL !== 1'b0 || TX_DATA !== 16'h0) begin errors++; $display("FAIL rstmid_tx: got %b %h expected 0 0000", TX_DATA_VAL, TX_DATA); end
        RST = 1'b0;
        n = 0;
        while (TX_DATA_VAL !== 1'b1 && n < 20) begin @(posedge CLK); #1; n++; end
        checks++; if (REQ_ACK !== 4'b0001 || TX_DATA !== 16'h0F0F) begin errors++; $display("FAIL rstmid_priority: got ack %b data %h expected 0001 0f0f", REQ_ACK, TX_DATA); end
        REQ_VAL = 4'b0000;
        repeat (10) @(posedge CLK); #1;
    endtask

    task automatic test_stats();
        logic [31:0] exp_stat;
        do_reset(); clear_queues();
        for (int w = 0; w < 10; w++) push_word(1, 16'h7700 + 16'(w), (w % 3) == 2);
        run_traffic(2000, 1'b0);
        checks++; if (timed_out || obs_req.size() != 10) begin errors++; $display("FAIL stats_words: got %0d expected 10", obs_req.size()); end
`ifdef UART_TX_ARB_STATS_EN
        exp_stat = 32'd10;
`else
        exp_stat = 32'd0;
`endif
        checks++; if (STAT_WORDS !== exp_stat) begin errors++; $display("FAIL stats_count: got %0d expected %0d", STAT_WORDS, exp_stat); end
    endtask

    task automatic test_random();
        logic [31:0] exp_stat;
        for (int r = 0; r < 3; r++) begin
            do_reset(); clear_queues();
            for (int i = 0; i < c_NR; i++) begin
                int n = $urandom_range(0, 10);
                for (int w = 0; w < n; w++) push_word(i, 16'($urandom), $urandom_range(0, 2) == 0);
            end
            build_expected();
            run_traffic(4000, 1'b1);
            checks++; if (timed_out) begin errors++; $display("FAIL rand%0d_timeout: got timeout expected completion", r); end
            checks++; if (obs_req.size() != exp_req.size()) begin errors++; $display("FAIL rand%0d_count: got %0d expected %0d", r, obs_req.size(), exp_req.size()); end
            for (int k = 0; k < exp_req.size() && k < obs_req.size(); k++) begin
                checks++; if (obs_req[k] != exp_req[k] || obs_data[k] !== exp_data[k]) begin
                    errors++; $display("FAIL rand%0d_word%0d: got req %0d data %h expected req %0d data %h", r, k, obs_req[k], obs_data[k], exp_req[k], exp_data[k]);
                end
            end
            checks++; if (viol_busy != 0) begin errors++; $display("FAIL rand%0d_busy: got %0d strobes while busy expected 0", r, viol_busy); end
            checks++; if (viol_ack != 0) begin errors++; $display("FAIL rand%0d_ack: got %0d ack/grant errors expected 0", r, viol_ack); end
            checks++; if (viol_gap != 0) begin errors++; $display("FAIL rand%0d_gap: got %0d short gaps expected 0", r, viol_gap); end
`ifdef UART_TX_ARB_STATS_EN
            exp_stat = 32'(obs_req.size());
`else
            exp_stat = 32'd0;
`endif
            checks++; if (STAT_WORDS !== exp_stat) begin errors++; $display("FAIL rand%0d_stat: got %0d expected %0d", r, STAT_WORDS, exp_stat); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_burst();
        test_busy_gating();
        test_reset_mid();
        test_stats();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
